// File: rtl/sc_pkg.sv
// sc_pkg: shared constants, FSM state type and bit-reverse helper for the SC datapath.
package sc_pkg;
  localparam int SC_WIDTH = 4;
  typedef enum logic {IDLE, RUN} sng_state_t;
  function automatic logic [31:0] bit_reverse(input logic [31:0] x, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = x[w-1-i];
    return r;
  endfunction
endpackage

// File: rtl/sc_rev_counter.sv
// sc_rev_counter: WIDTH-bit counter with clear/enable, exposing the count and its
// bit-reversed (Van der Corput) form.
module sc_rev_counter import sc_pkg::*; #(
  parameter int WIDTH = SC_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] rev
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + WIDTH'(1) : cnt_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
  assign rev = WIDTH'(bit_reverse(32'(cnt_q), WIDTH));
endmodule

// File: rtl/sc_sng.sv
// sc_sng: converts a WIDTH-bit operand into a 2^WIDTH-bit unipolar low-discrepancy stream.
// Optional SC_SNG_ONES_COUNT_EN adds ones_count/count_valid for self-checking the stream.
module sc_sng import sc_pkg::*; #(
  parameter int WIDTH = SC_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_out,
  output logic             bit_last,
`ifdef SC_SNG_ONES_COUNT_EN
  output logic [WIDTH:0]   ones_count,
  output logic             count_valid,
`endif
  output logic             busy
);
  sng_state_t       state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d, cnt, rev;
  logic             hs, acc, done;
  assign hs   = in_valid && (state_q == IDLE);
  assign acc  = (state_q == RUN) && bit_ready;
  assign done = acc && (cnt == '1);
  sc_rev_counter #(.WIDTH(WIDTH)) u_cnt (
    .clock(clock),
    .reset(reset),
    .clr  (hs || done),
    .en   (acc),
    .cnt  (cnt),
    .rev  (rev)
  );
  always_comb begin
    state_d   = hs ? RUN : done ? IDLE : state_q;
    value_d   = hs ? in_value : value_q;
    in_ready  = (state_q == IDLE);
    busy      = (state_q == RUN);
    bit_valid = busy;
    bit_out   = busy && (value_q > rev);
    bit_last  = busy && (cnt == '1);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
    end
`ifdef SC_SNG_ONES_COUNT_EN
  logic [WIDTH:0] ones_q, ones_d;
  logic           cv_q, cv_d;
  always_comb begin
    ones_d = hs ? '0 : (acc && bit_out) ? ones_q + (WIDTH+1)'(1) : ones_q;
    cv_d   = done;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ones_q <= '0;
      cv_q   <= 1'b0;
    end else begin
      ones_q <= ones_d;
      cv_q   <= cv_d;
    end
  assign ones_count  = ones_q;
  assign count_valid = cv_q;
`endif
endmodule

// File: tb/tb_sc_sng.sv
// tb_sc_sng: randomized and directed self-checking bench for sc_sng against a stream model.
module tb_sc_sng;
  localparam int W = 4;
  localparam int N = 1 << W;
  logic clock, reset, in_valid, in_ready, bit_valid, bit_ready, bit_out, bit_last, busy;
  logic [W-1:0] in_value;
`ifdef SC_SNG_ONES_COUNT_EN
  logic [W:0] ones_count;
  logic       count_valid;
`endif
  int n_cmp = 0, n_bad = 0;

  sc_sng #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .bit_out(bit_out), .bit_last(bit_last),
`ifdef SC_SNG_ONES_COUNT_EN
    .ones_count(ones_count), .count_valid(count_valid),
`endif
    .busy(busy)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  function automatic int vdc(input int k);
    int r = 0;
    for (int i = 0; i < W; i++) r += ((k >> i) % 2) * (1 << (W - 1 - i));
    return r;
  endfunction

  function automatic logic [N-1:0] model(input int v);
    logic [N-1:0] s = '0;
    for (int k = 0; k < N; k++) s[k] = (v > vdc(k));
    return s;
  endfunction

  task automatic send(input int v);
    in_valid = 1;
    in_value = W'(v);
    @(negedge clock);
    in_valid = 0;
  endtask

  task automatic capture(input bit rnd, input int st_at, input int st_len,
                         output logic [N-1:0] bits, output logic [N-1:0] lasts,
                         output int cycles, output bit ok);
    int idx = 0, stl = 0;
    bit pend = 0, stall;
    logic hb = 0, hl = 0;
    bits = '0; lasts = '0; cycles = 0; ok = 1;
    while (idx < N && cycles < 200) begin
      if (!bit_valid) ok = 0;
      if (pend && (bit_out !== hb || bit_last !== hl)) ok = 0;
      stall = rnd ? ($urandom_range(0, 2) == 0) : (idx == st_at && stl < st_len);
      bit_ready = !stall;
      if (stall) begin
        if (!pend) begin hb = bit_out; hl = bit_last; pend = 1; end
        stl++;
      end else begin
        bits[idx] = bit_out;
        lasts[idx] = bit_last;
        pend = 0;
        idx++;
      end
      @(negedge clock);
      cycles++;
    end
    if (idx < N) ok = 0;
    bit_ready = 1;
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({in_ready, bit_valid, bit_out, bit_last, busy} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_outs got=%b want=10000", {in_ready, bit_valid, bit_out, bit_last, busy});
    end
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    n_cmp++;
    if (in_ready !== 1 || busy !== 0) begin
      n_bad++;
      $display("FAIL idle_after_reset in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
  endtask

  task automatic test_value5;
    logic [N-1:0] b, l; int c; bit ok;
    send(5);
    capture(0, -1, 0, b, l, c, ok);
    n_cmp++;
    if (b !== model(5) || b !== 16'b0001000100010101) begin
      n_bad++; $display("FAIL v5_bits got=%b want=%b", b, model(5));
    end
    n_cmp++;
    if (l !== 16'h8000 || $countones(b) != 5) begin
      n_bad++; $display("FAIL v5_last_ones last=%h ones=%0d want 8000/5", l, $countones(b));
    end
    n_cmp++;
    if (c != N || ok !== 1 || in_ready !== 1 || bit_valid !== 0) begin
      n_bad++; $display("FAIL v5_timing cycles=%0d ok=%b in_ready=%b bit_valid=%b want %0d/1/1/0", c, ok, in_ready, bit_valid, N);
    end
  endtask

  task automatic test_edges;
    logic [N-1:0] b, l; int c; bit ok;
    send(0);
    capture(0, -1, 0, b, l, c, ok);
    n_cmp++;
    if (b !== '0 || l !== 16'h8000 || !ok) begin
      n_bad++; $display("FAIL v0_stream bits=%b last=%h ok=%b want 0/8000/1", b, l, ok);
    end
    send(N - 1);
    capture(0, -1, 0, b, l, c, ok);
    n_cmp++;
    if (b !== 16'h7fff || l !== 16'h8000 || !ok) begin
      n_bad++; $display("FAIL v15_stream bits=%h last=%h ok=%b want 7fff/8000/1", b, l, ok);
    end
  endtask

  task automatic test_stall;
    logic [N-1:0] b, l; int c; bit ok;
    send(9);
    capture(0, 4, 3, b, l, c, ok);
    n_cmp++;
    if (b !== model(9) || l !== 16'h8000) begin
      n_bad++; $display("FAIL stall_bits got=%b want=%b last=%h", b, model(9), l);
    end
    n_cmp++;
    if (c != N + 3 || ok !== 1) begin
      n_bad++; $display("FAIL stall_hold cycles=%0d ok=%b want %0d/1", c, ok, N + 3);
    end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] b, l; int c; bit ok;
    send(7);
    in_valid = 1;
    in_value = 12;
    capture(0, -1, 0, b, l, c, ok);
    n_cmp++;
    if (b !== model(7) || !ok) begin
      n_bad++; $display("FAIL b2b_first got=%b want=%b ok=%b", b, model(7), ok);
    end
    n_cmp++;
    if (in_ready !== 1 || bit_valid !== 0) begin
      n_bad++; $display("FAIL b2b_bubble in_ready=%b bit_valid=%b want 1/0", in_ready, bit_valid);
    end
    @(negedge clock);
    in_valid = 0;
    capture(0, -1, 0, b, l, c, ok);
    n_cmp++;
    if (b !== model(12) || !ok) begin
      n_bad++; $display("FAIL b2b_second got=%b want=%b ok=%b", b, model(12), ok);
    end
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] b, l; int c; bit ok;
    send(10);
    bit_ready = 1;
    repeat (6) @(negedge clock);
    #2 reset = 1;
    #1;
    n_cmp++;
    if ({in_ready, bit_valid, bit_out, bit_last, busy} !== 5'b10000) begin
      n_bad++; $display("FAIL mid_reset got=%b want=10000", {in_ready, bit_valid, bit_out, bit_last, busy});
    end
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    send(3);
    capture(0, -1, 0, b, l, c, ok);
    n_cmp++;
    if (b !== model(3) || $countones(b) != 3 || !ok) begin
      n_bad++; $display("FAIL post_reset got=%b want=%b ok=%b", b, model(3), ok);
    end
  endtask

  task automatic test_random;
    logic [N-1:0] b, l; int c, v; bit ok;
    repeat (8) begin
      v = $urandom_range(0, N - 1);
      send(v);
      capture(1, -1, 0, b, l, c, ok);
      n_cmp++;
      if (b !== model(v) || l !== 16'h8000 || !ok) begin
        n_bad++; $display("FAIL rand_v%0d got=%b want=%b last=%h ok=%b", v, b, model(v), l, ok);
      end
    end
  endtask

`ifdef SC_SNG_ONES_COUNT_EN
  task automatic test_ones_count;
    logic [N-1:0] b, l; int c; bit ok;
    send(11);
    capture(1, -1, 0, b, l, c, ok);
    n_cmp++;
    if (count_valid !== 1 || ones_count !== 11) begin
      n_bad++; $display("FAIL ones_count cv=%b cnt=%0d want 1/11", count_valid, ones_count);
    end
    @(negedge clock);
    n_cmp++;
    if (count_valid !== 0) begin
      n_bad++; $display("FAIL cv_pulse cv=%b want 0", count_valid);
    end
  endtask
`endif

  initial begin
    reset = 1; in_valid = 0; in_value = 0; bit_ready = 1;
    @(negedge clock);
    test_reset;
    test_value5;
    test_edges;
    test_stall;
    test_back_to_back;
    test_reset_mid;
    test_random;
`ifdef SC_SNG_ONES_COUNT_EN
    test_ones_count;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
